mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 19 +
 rtl/byte_lane_merge.sv | 24 ++
 rtl/mem_access_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the CPU data-memory access controller.
package mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    WAIT,
    MERGE,
    RESP
  } state_t;

  // Word-index width of the data RAM for a given byte-address width.
  function automatic int ram_idx_w(input int addr_w);
    return addr_w - 2;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian byte-lane extract and replace on a 32-bit word.
module byte_lane_merge
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [7:0]        new_byte,
  output logic [7:0]        ext_byte,
  output logic [DATA_W-1:0] merged
);

  logic [4:0]        sh;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  always_comb begin
    sh       = {lane, 3'b000};
    shifted  = word >> sh;
    ext_byte = shifted[7:0];
    mask     = {{(DATA_W-8){1'b0}}, 8'hFF} << sh;
    merged   = (word & ~mask) | ({{(DATA_W-8){1'b0}}, new_byte} << sh);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU load/store front end to a single-port synchronous data RAM; byte stores are read-modify-write.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  import mem_pkg::*;

  localparam int IDX_W = ram_idx_w(ADDR_W);

  state_t            state;
  logic              ram_we_q;
  logic              lat_write;
  logic              lat_byte;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [IDX_W-1:0]  word_idx;
  logic [7:0]        lane_byte;
  logic [DATA_W-1:0] merged;

  assign word_idx = req_addr[ADDR_W-1:2];

  byte_lane_merge u_lane (
    .word     (ram_dout),
    .lane     (lat_addr[1:0]),
    .new_byte (lat_wdata[7:0]),
    .ext_byte (lane_byte),
    .merged   (merged)
  );

  // Reset gates the registered strobes combinationally so a write in flight is dropped in the same cycle.
  assign req_ready = (state == IDLE) && !rst;
  assign ram_we    = ram_we_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_we_q  <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_write <= 1'b0;
      lat_byte  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_byte  <= req_byte;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (!req_byte && (req_addr[1:0] != 2'b00)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state    <= ACC;
              ram_addr <= word_idx;
              ram_we_q <= req_write && !req_byte;
              ram_din  <= (req_write && !req_byte) ? req_wdata : '0;
            end
          end
        end
        ACC: begin
          ram_we_q <= 1'b0;
          if (lat_write && !lat_byte) begin
            state     <= RESP;
            ram_addr  <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (lat_write) begin
            state    <= MERGE;
            ram_we_q <= 1'b1;
            ram_din  <= merged;
          end else begin
            state     <= RESP;
            ram_addr  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= lat_byte ? {{(DATA_W-8){1'b0}}, lane_byte} : ram_dout;
          end
        end
        MERGE: begin
          state     <= RESP;
          ram_we_q  <= 1'b0;
          ram_addr  <= '0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
